wave_ram_arbiter: RTL and testbench
===================================

WAVE_RAM_ARBITER -- requirements
Module: wave_ram_arbiter

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high, with ports named clk and reset.
REQ-002 Parameter NCH SHALL default to 4 and sets the number of capture channels; all widths below assume NCH=4.
REQ-003 Port clk, input, 1: the system clock.
REQ-004 Port reset, input, 1: synchronous active-high reset.
REQ-005 Port ch_we, input, 4: per-channel write strobe, one cycle per sample.
REQ-006 Port ch_addr, input, 36: per-channel 9-bit write address; channel i occupies bits [9i+8:9i].
REQ-007 Port ch_data, input, 32: per-channel 8-bit sample; channel i occupies bits [8i+7:8i].
REQ-008 Port ch_mask, input, 4: per-channel enable; 1 means the channel is enabled.
REQ-009 Port overflow_clr, input, 1: clears all overflow flags.
REQ-010 Port ram_we, output, 1: shared RAM write enable.
REQ-011 Port ram_addr, output, 11: shared RAM address, formed as {channel[1:0], addr[8:0]}.
REQ-012 Port ram_din, output, 8: shared RAM write data.
REQ-013 Port pending, output, 4: per-channel holding-buffer valid bit.
REQ-014 Port overflow, output, 4: per-channel sticky flag marking a lost sample.

Function
REQ-015 Each channel SHALL have a one-entry holding buffer storing valid, 9-bit addr and 8-bit data; pending[i] SHALL equal buffer i valid.
REQ-016 Capture: on a clock edge with ch_we[i]=1 and ch_mask[i]=1, buffer i SHALL load ch_addr/ch_data for channel i and set valid to 1.
REQ-017 A strobe with ch_mask[i]=0 SHALL be dropped, leaving the buffer and overflow[i] unchanged.
REQ-018 Arbitration SHALL happen at every edge: among buffers valid before the edge with mask=1, the first in round-robin order starting at the 2-bit pointer rr_ptr SHALL be granted.
REQ-019 On a grant to channel g, the block SHALL register ram_we=1, ram_addr={g, addr_g} and ram_din=data_g, clear valid_g, and set rr_ptr to g+1 mod 4.
REQ-020 With no eligible buffer, the block SHALL register ram_we=0, hold ram_addr and ram_din at their previous values, and leave rr_ptr unchanged.
REQ-021 Latency: a strobe in cycle t on an uncontended channel SHALL produce ram_we=1 in cycle t+2 with the same addr/data; ram_we SHALL be high for exactly one cycle per granted sample.
REQ-022 At most one RAM write SHALL occur per cycle; four simultaneous strobes SHALL produce writes in cycles t+2..t+5, ordered from rr_ptr.
REQ-023 Grant and new strobe on the same channel at the same edge: the buffer SHALL reload with the new sample, valid SHALL stay 1, and no overflow SHALL be flagged.
REQ-024 A strobe on a channel whose buffer is valid and not granted at that edge SHALL overwrite the buffer with the newest sample and set overflow[i] to 1.
REQ-025 overflow bits SHALL be sticky until overflow_clr; when overflow_clr and a new overflow occur at the same edge, the set SHALL win for that bit and all other bits SHALL clear.
REQ-026 A valid buffer whose ch_mask bit is 0 at an edge SHALL be discarded (valid to 0), not granted, and SHALL not affect overflow.
REQ-027 An address field of 511 SHALL pass through unchanged; the channel field SHALL never carry into the address bits.

Reset
REQ-028 While reset=1 at an edge, all buffer valid bits, pending, overflow, ram_we, ram_addr, ram_din and rr_ptr SHALL become 0.
REQ-029 Reset SHALL take priority over capture and grant at the same edge; strobes at that edge are discarded and no write occurs in the following cycle.
REQ-030 Reset asserted mid-burst SHALL discard all pending samples, and no further ram_we SHALL occur until a new strobe.

Verification
REQ-031 Single sample: mask=4'hF, ch_we=4'b0100, ch2 addr=9'h1A5, data=8'h7E at t -> ram_we=1 at t+2, ram_addr=11'h5A5, ram_din=8'h7E, one cycle only.
REQ-032 Burst: after reset, all four strobe at t with data 8'h10..8'h13 -> writes at t+2..t+5 in channel order 0,1,2,3; pending returns to 4'h0 at t+5; overflow stays 4'h0.
REQ-033 Round-robin: with rr_ptr=2, ch0 and ch3 pending -> ch3 is written first, then ch0.
REQ-034 Overflow: ch1 strobes at t and t+1 while ch0 holds the grant at t+1 -> overflow=4'b0010 and the ch1 write carries the t+1 data; overflow_clr then clears it to 0.
REQ-035 Mask and reset: a ch3 strobe with mask[3]=0 produces no write; reset asserted with pending=4'hF gives all outputs 0 on the next cycle and no write.

Source files
------------

// File: rtl/wave_ram_arbiter.sv
// wave_ram_arbiter
//   Funnels NCH capture channels into one shared waveform RAM write port.
//   Each channel owns a one-entry holding buffer (valid/addr/data). Every
//   clock edge a round-robin arbiter grants one eligible buffer and registers
//   the RAM write; a sample that is overwritten before it is granted raises
//   a sticky per-channel overflow flag.
//
// Ports
//   clk           system clock
//   reset         synchronous active-high reset
//   ch_we         per-channel write strobe (one cycle per sample)
//   ch_addr       per-channel 9-bit address, channel i at [9i+8:9i]
//   ch_data       per-channel 8-bit sample, channel i at [8i+7:8i]
//   ch_mask       per-channel enable (1 = enabled)
//   overflow_clr  clears all overflow flags
//   ram_we        shared RAM write enable (registered)
//   ram_addr      shared RAM address {channel, addr} (registered)
//   ram_din       shared RAM write data (registered)
//   pending       per-channel holding-buffer valid
//   overflow      per-channel sticky lost-sample flag
module wave_ram_arbiter #(
  parameter int NCH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NCH-1:0]                ch_we,
  input  logic [9*NCH-1:0]              ch_addr,
  input  logic [8*NCH-1:0]              ch_data,
  input  logic [NCH-1:0]                ch_mask,
  input  logic                          overflow_clr,
  output logic                          ram_we,
  output logic [$clog2(NCH)+8:0]        ram_addr,
  output logic [7:0]                    ram_din,
  output logic [NCH-1:0]                pending,
  output logic [NCH-1:0]                overflow
);

  localparam int CW = $clog2(NCH);

  logic [8:0]     addr_reg  [NCH];
  logic [7:0]     data_reg  [NCH];
  logic [NCH-1:0] valid_reg;
  logic [NCH-1:0] overflow_reg;
  logic [CW-1:0]  rr_ptr_reg;

  logic [8:0]     ch_addr_a [NCH];
  logic [7:0]     ch_data_a [NCH];
  logic [NCH-1:0] eligible;
  logic [NCH-1:0] grant_oh;
  logic [NCH-1:0] ovf_set;
  logic           grant_valid;
  logic [CW-1:0]  grant_idx;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      assign ch_addr_a[gi] = ch_addr[9*gi +: 9];
      assign ch_data_a[gi] = ch_data[8*gi +: 8];
      // Only buffers already holding a sample and still enabled compete.
      assign eligible[gi]  = valid_reg[gi] & ch_mask[gi];
      assign grant_oh[gi]  = grant_valid && (grant_idx == CW'(gi));
      // A new sample landing on an occupied, un-granted buffer loses the old one.
      assign ovf_set[gi]   = ch_we[gi] & ch_mask[gi] & valid_reg[gi] & ~grant_oh[gi];
    end
  endgenerate

  // Round-robin search starting at rr_ptr. Scanning offsets from highest to
  // lowest lets the nearest eligible channel overwrite any farther one.
  always_comb begin
    int idx;
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int k = NCH - 1; k >= 0; k--) begin
      idx = int'(rr_ptr_reg) + k;
      if (idx >= NCH) idx = idx - NCH;
      if (eligible[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = CW'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_reg    <= '0;
      overflow_reg <= '0;
      rr_ptr_reg   <= '0;
      ram_we       <= 1'b0;
      ram_addr     <= '0;
      ram_din      <= '0;
      for (int i = 0; i < NCH; i++) begin
        addr_reg[i] <= '0;
        data_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (!ch_mask[i]) begin
          // Disabled channel: drop strobes and discard any held sample.
          valid_reg[i] <= 1'b0;
        end else if (ch_we[i]) begin
          // Capture wins over a same-edge grant, so the buffer reloads.
          valid_reg[i] <= 1'b1;
          addr_reg[i]  <= ch_addr_a[i];
          data_reg[i]  <= ch_data_a[i];
        end else if (grant_oh[i]) begin
          valid_reg[i] <= 1'b0;
        end
      end

      // Set takes priority over clear for the bits that overflow this edge.
      overflow_reg <= (overflow_clr ? '0 : overflow_reg) | ovf_set;

      ram_we <= grant_valid;
      if (grant_valid) begin
        ram_addr   <= {grant_idx, addr_reg[grant_idx]};
        ram_din    <= data_reg[grant_idx];
        rr_ptr_reg <= (grant_idx == CW'(NCH - 1)) ? '0 : grant_idx + 1'b1;
      end
    end
  end

  assign pending  = valid_reg;
  assign overflow = overflow_reg;

endmodule

// File: tb/tb_wave_ram_arbiter.sv
module tb_wave_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  ch_we;
  logic [35:0] ch_addr;
  logic [31:0] ch_data;
  logic [3:0]  ch_mask;
  logic        overflow_clr;
  logic        ram_we;
  logic [10:0] ram_addr;
  logic [7:0]  ram_din;
  logic [3:0]  pending;
  logic [3:0]  overflow;

  always #5 clk = ~clk;

  wave_ram_arbiter #(.NCH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .ch_we        (ch_we),
    .ch_addr      (ch_addr),
    .ch_data      (ch_data),
    .ch_mask      (ch_mask),
    .overflow_clr (overflow_clr),
    .ram_we       (ram_we),
    .ram_addr     (ram_addr),
    .ram_din      (ram_din),
    .pending      (pending),
    .overflow     (overflow)
  );

  typedef struct {
    int          cyc;
    logic [10:0] addr;
    logic [7:0]  din;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every RAM write is matched against the next expected write.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (ram_we === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr=%0h din=%0h at cycle %0d, required no write",
                   ram_addr, ram_din, cyc);
        end else begin
          e = sb.pop_front();
          $display("write cycle=%0d addr=%0h din=%0h (expected cycle=%0d addr=%0h din=%0h)",
                   cyc, ram_addr, ram_din, e.cyc, e.addr, e.din);
          chk("wr_cycle", cyc, e.cyc);
          chk("wr_addr", {21'd0, ram_addr}, {21'd0, e.addr});
          chk("wr_din", {24'd0, ram_din}, {24'd0, e.din});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    ch_we        = '0;
    overflow_clr = 1'b0;
  endtask

  task automatic drive(int ch, logic [8:0] a, logic [7:0] d);
    ch_we[ch]          = 1'b1;
    ch_addr[9*ch +: 9] = a;
    ch_data[8*ch +: 8] = d;
  endtask

  task automatic expect_wr(int c, logic [10:0] a, logic [7:0] d);
    exp_t e;
    e.cyc  = c;
    e.addr = a;
    e.din  = d;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int c;
    reset        = 1'b0;
    ch_we        = '0;
    ch_addr      = '0;
    ch_data      = '0;
    ch_mask      = 4'hF;
    overflow_clr = 1'b0;
    #1;
    do_reset();
    do_reset();
    chk("rst_ram_we", {31'd0, ram_we}, 32'd0);
    chk("rst_ram_addr", {21'd0, ram_addr}, 32'd0);
    chk("rst_ram_din", {24'd0, ram_din}, 32'd0);
    chk("rst_pending", {28'd0, pending}, 32'd0);
    chk("rst_overflow", {28'd0, overflow}, 32'd0);

    // Single sample on ch2.
    c = cyc;
    drive(2, 9'h1A5, 8'h7E);
    expect_wr(c + 2, 11'h5A5, 8'h7E);
    tick();
    chk("single_pending", {28'd0, pending}, 32'h4);
    repeat (4) tick();

    // Burst on all four channels, ch3 at address 511.
    do_reset();
    c = cyc;
    drive(0, 9'h010, 8'h10);
    drive(1, 9'h021, 8'h11);
    drive(2, 9'h132, 8'h12);
    drive(3, 9'h1FF, 8'h13);
    expect_wr(c + 2, 11'h010, 8'h10);
    expect_wr(c + 3, 11'h221, 8'h11);
    expect_wr(c + 4, 11'h532, 8'h12);
    expect_wr(c + 5, 11'h7FF, 8'h13);
    tick(); chk("burst_pend_t1", {28'd0, pending}, 32'hF);
    tick(); chk("burst_pend_t2", {28'd0, pending}, 32'hE);
    tick(); chk("burst_pend_t3", {28'd0, pending}, 32'hC);
    tick(); chk("burst_pend_t4", {28'd0, pending}, 32'h8);
    tick(); chk("burst_pend_t5", {28'd0, pending}, 32'h0);
    chk("burst_overflow", {28'd0, overflow}, 32'h0);
    tick();

    // Round robin: grant ch1 alone so rr_ptr becomes 2, then ch0 + ch3.
    do_reset();
    c = cyc;
    drive(1, 9'h044, 8'h21);
    expect_wr(c + 2, 11'h244, 8'h21);
    tick();
    tick();
    c = cyc;
    drive(0, 9'h055, 8'h30);
    drive(3, 9'h066, 8'h33);
    expect_wr(c + 2, 11'h666, 8'h33);
    expect_wr(c + 3, 11'h055, 8'h30);
    repeat (5) tick();

    // Overflow: ch1 strobes twice while ch0 takes the grant.
    do_reset();
    c = cyc;
    drive(0, 9'h0A0, 8'hA0);
    drive(1, 9'h0B0, 8'hB0);
    expect_wr(c + 2, 11'h0A0, 8'hA0);
    expect_wr(c + 3, 11'h2B1, 8'hB1);
    tick();
    drive(1, 9'h0B1, 8'hB1);
    tick();
    chk("ovf_set", {28'd0, overflow}, 32'h2);
    tick();
    tick();
    chk("ovf_sticky", {28'd0, overflow}, 32'h2);

    // Clear and new overflow at the same edge: new bit wins, others clear.
    c = cyc;
    drive(2, 9'h0C2, 8'hC2);
    drive(3, 9'h0D3, 8'hD3);
    expect_wr(c + 2, 11'h4C2, 8'hC2);
    expect_wr(c + 3, 11'h6D4, 8'hD4);
    tick();
    drive(3, 9'h0D4, 8'hD4);
    overflow_clr = 1'b1;
    tick();
    chk("ovf_set_wins", {28'd0, overflow}, 32'h8);
    tick();
    tick();
    overflow_clr = 1'b1;
    tick();
    chk("ovf_clr", {28'd0, overflow}, 32'h0);

    // Grant and strobe on the same channel: reload, no overflow.
    c = cyc;
    drive(0, 9'h0E0, 8'hE0);
    expect_wr(c + 2, 11'h0E0, 8'hE0);
    expect_wr(c + 3, 11'h0E1, 8'hE1);
    tick();
    drive(0, 9'h0E1, 8'hE1);
    tick();
    chk("reload_no_ovf", {28'd0, overflow}, 32'h0);
    chk("reload_pending", {28'd0, pending}, 32'h1);
    tick();
    tick();
    chk("reload_drained", {28'd0, pending}, 32'h0);

    // Masked strobe is dropped.
    do_reset();
    ch_mask = 4'b0111;
    drive(3, 9'h077, 8'h77);
    tick();
    chk("mask_drop_pend", {28'd0, pending}, 32'h0);
    tick();
    tick();
    ch_mask = 4'hF;

    // Valid buffer discarded when its mask drops.
    c = cyc;
    drive(0, 9'h011, 8'h51);
    drive(1, 9'h012, 8'h52);
    expect_wr(c + 2, 11'h011, 8'h51);
    tick();
    ch_mask = 4'b1101;
    tick();
    ch_mask = 4'hF;
    chk("mask_discard_pend", {28'd0, pending}, 32'h0);
    chk("mask_discard_ovf", {28'd0, overflow}, 32'h0);
    repeat (3) tick();

    // Reset with all buffers pending, plus a strobe at the reset edge.
    do_reset();
    drive(0, 9'h101, 8'h91);
    drive(1, 9'h102, 8'h92);
    drive(2, 9'h103, 8'h93);
    drive(3, 9'h104, 8'h94);
    tick();
    chk("pre_rst_pending", {28'd0, pending}, 32'hF);
    reset = 1'b1;
    drive(2, 9'h105, 8'h95);
    tick();
    reset = 1'b0;
    chk("midrst_ram_we", {31'd0, ram_we}, 32'd0);
    chk("midrst_ram_addr", {21'd0, ram_addr}, 32'd0);
    chk("midrst_ram_din", {24'd0, ram_din}, 32'd0);
    chk("midrst_pending", {28'd0, pending}, 32'd0);
    chk("midrst_overflow", {28'd0, overflow}, 32'd0);
    repeat (4) tick();

    chk("sb_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
